// File: rtl/biu_icu_line_responder.sv
// Purpose : BIU stand-in that answers one icache line-fill with an ack pulse and four 64-bit beats read from a preloadable store.
// Latency : ack one cycle after req is sampled; first beat LAT cycles after the ack; beats spaced BEAT_GAP+1 cycles apart.
// Backpressure: none; the icache must always take beats, and req is ignored until the line has been returned.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   icu_biu_req/icu_biu_addr    line-fill request (held until ack) and dword address [31:3]
//   biu_icu_ack                 one-cycle acceptance pulse
//   biu_icu_data_valid/_data/_data_last   beat stream, last marks the 4th beat
//   biu_busy                    high from the ack cycle through the final beat
//   mem_we/mem_waddr/mem_wdata  preload/write port of the doubleword store
module biu_icu_line_responder #(
    parameter int MEM_AW   = 16,
    parameter int LAT      = 2,
    parameter int BEAT_GAP = 0,
    parameter int WRAP     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              icu_biu_req,
    input  logic [28:0]       icu_biu_addr,
    output logic              biu_icu_ack,
    output logic              biu_icu_data_valid,
    output logic [63:0]       biu_icu_data,
    output logic              biu_icu_data_last,
    output logic              biu_busy,
    input  logic              mem_we,
    input  logic [MEM_AW-1:0] mem_waddr,
    input  logic [63:0]       mem_wdata
);

    typedef enum logic [2:0] {S_IDLE, S_ACK, S_WAIT, S_BEAT, S_GAP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);
    localparam logic [1:0] GAP_M1 = 2'((BEAT_GAP > 0) ? (BEAT_GAP - 1) : 0);

    state_t            state_q;
    logic [MEM_AW-1:0] addr_q;      // request dword index; address bits above the store alias away
    logic [3:0]        lat_q;
    logic [1:0]        gap_q;
    logic [1:0]        beat_q;      // index k of the beat most recently presented
    logic              ack_q;
    logic              vld_q;
    logic              last_q;
    logic              busy_q;
    logic [63:0]       data_q;

    logic [63:0]       mem_q [2**MEM_AW];

    logic [1:0]        k_d;
    logic [1:0]        idx_d;
    logic [MEM_AW-1:0] rd_idx_d;
    logic [63:0]       rd_data_d;
    logic              fire_d;

    if (MEM_AW < 29) begin : g_alias
        logic unused_addr_hi;
        assign unused_addr_hi = ^icu_biu_addr[28:MEM_AW];
    end

    // Beat data is fetched in the cycle before it is presented, so a write
    // landing on the edge that starts the beat must be forwarded; a write
    // during the beat cycle itself lands after the beat was captured.
    always_comb begin
        k_d       = (state_q == S_BEAT || state_q == S_GAP) ? beat_q + 2'd1 : 2'd0;
        idx_d     = (WRAP != 0) ? addr_q[1:0] + k_d : k_d;
        rd_idx_d  = {addr_q[MEM_AW-1:2], idx_d};
        rd_data_d = (mem_we && mem_waddr == rd_idx_d) ? mem_wdata : mem_q[rd_idx_d];
        fire_d    = (state_q == S_ACK  && LAT == 1)
                 || (state_q == S_WAIT && lat_q == 4'd1)
                 || (state_q == S_BEAT && beat_q != 2'd3 && BEAT_GAP == 0)
                 || (state_q == S_GAP  && gap_q == 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            lat_q   <= '0;
            gap_q   <= '0;
            beat_q  <= '0;
            ack_q   <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= 64'h0;
        end else begin
            ack_q  <= 1'b0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (icu_biu_req) begin
                        addr_q  <= icu_biu_addr[MEM_AW-1:0];
                        ack_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    lat_q   <= LAT_M1;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    lat_q <= lat_q - 4'd1;
                end
                S_BEAT: begin
                    if (beat_q == 2'd3) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (BEAT_GAP != 0) begin
                        gap_q   <= GAP_M1;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q != 2'd0) begin
                        gap_q <= gap_q - 2'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Launching a beat overrides whatever state the case picked.
            if (fire_d) begin
                state_q <= S_BEAT;
                beat_q  <= k_d;
                vld_q   <= 1'b1;
                last_q  <= (k_d == 2'd3);
                data_q  <= rd_data_d;
            end
        end
    end

    // Store contents survive reset; writes are accepted in every state.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign biu_icu_ack        = ack_q;
    assign biu_icu_data_valid = vld_q;
    assign biu_icu_data       = data_q;
    assign biu_icu_data_last  = last_q;
    assign biu_busy           = busy_q;

endmodule

// File: tb/tb_biu_icu_line_responder.sv
module tb_biu_icu_line_responder;

    localparam logic [63:0] DB = 64'hbbbb_bbbb_bbbb_bbbb;
    localparam logic [63:0] DC = 64'hcccc_cccc_cccc_cccc;
    localparam logic [63:0] DD = 64'hdddd_dddd_dddd_dddd;
    localparam logic [63:0] DE = 64'heeee_eeee_eeee_eeee;
    localparam logic [63:0] D5 = 64'h5555_5555_5555_5555;
    localparam logic [63:0] D7 = 64'h7777_7777_7777_7777;

    // Three instances: 0 = WRAP1/LAT2/GAP0, 1 = WRAP0/LAT2/GAP0, 2 = WRAP1/LAT1/GAP2
    int lat_p [3] = '{2, 2, 1};
    int gap_p [3] = '{0, 0, 2};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_i  [3];
    logic [28:0] addr_i [3];
    logic        ack_o  [3];
    logic        vld_o  [3];
    logic [63:0] dat_o  [3];
    logic        lst_o  [3];
    logic        bsy_o  [3];
    logic        mem_we = 1'b0;
    logic [15:0] mem_waddr = '0;
    logic [63:0] mem_wdata = '0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          dut;
        logic [63:0] d;
        logic        l;
        int          cyc;
    } beat_t;
    beat_t sbq [$];

    typedef struct {
        int              sel;
        logic [28:0]     addr;
        logic            wr_en;
        int              wr_off;
        logic [15:0]     wr_idx;
        logic [63:0]     wr_dat;
        logic [3:0][63:0] exp;
    } vec_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    biu_icu_line_responder #(.MEM_AW(16), .LAT(2), .BEAT_GAP(0), .WRAP(1)) dut0 (
        .clk(clk), .reset(reset), .icu_biu_req(req_i[0]), .icu_biu_addr(addr_i[0]),
        .biu_icu_ack(ack_o[0]), .biu_icu_data_valid(vld_o[0]), .biu_icu_data(dat_o[0]),
        .biu_icu_data_last(lst_o[0]), .biu_busy(bsy_o[0]),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata));
    biu_icu_line_responder #(.MEM_AW(16), .LAT(2), .BEAT_GAP(0), .WRAP(0)) dut1 (
        .clk(clk), .reset(reset), .icu_biu_req(req_i[1]), .icu_biu_addr(addr_i[1]),
        .biu_icu_ack(ack_o[1]), .biu_icu_data_valid(vld_o[1]), .biu_icu_data(dat_o[1]),
        .biu_icu_data_last(lst_o[1]), .biu_busy(bsy_o[1]),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata));
    biu_icu_line_responder #(.MEM_AW(16), .LAT(1), .BEAT_GAP(2), .WRAP(1)) dut2 (
        .clk(clk), .reset(reset), .icu_biu_req(req_i[2]), .icu_biu_addr(addr_i[2]),
        .biu_icu_ack(ack_o[2]), .biu_icu_data_valid(vld_o[2]), .biu_icu_data(dat_o[2]),
        .biu_icu_data_last(lst_o[2]), .biu_busy(bsy_o[2]),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata));

    task automatic chk_b(string nm, logic act, logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b, expected %0b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_d(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_i(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every valid beat must match the oldest expected beat.
    always begin
        @(posedge clk);
        #1;
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                if (vld_o[i]) begin
                    if (sbq.size() == 0 || sbq[0].dut != i) begin
                        chk_b("unexpected_beat", 1'b1, 1'b0);
                    end else begin
                        beat_t b;
                        b = sbq.pop_front();
                        chk_d("beat_data", dat_o[i], b.d);
                        chk_b("beat_last", lst_o[i], b.l);
                        chk_i("beat_cycle", cyc, b.cyc);
                    end
                end else if (lst_o[i]) begin
                    chk_b("last_without_valid", lst_o[i], 1'b0);
                end
                if (ack_o[i] && vld_o[i]) begin
                    chk_b("ack_overlaps_valid", 1'b1, 1'b0);
                end
            end
        end
    end

    function automatic vec_t mk(int sel, logic [28:0] a, logic [63:0] e0, logic [63:0] e1,
                                logic [63:0] e2, logic [63:0] e3, logic we, int off,
                                logic [15:0] widx, logic [63:0] wdat);
        vec_t v;
        v.sel = sel; v.addr = a; v.wr_en = we; v.wr_off = off;
        v.wr_idx = widx; v.wr_dat = wdat;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    // Expected beat k of a request captured so that its ack is seen in cycle e.
    task automatic push_line(int sel, int e, logic [3:0][63:0] ex);
        for (int k = 0; k < 4; k++) begin
            beat_t b;
            b.dut = sel;
            b.d   = ex[k];
            b.l   = (k == 3);
            b.cyc = e + lat_p[sel] + k * (gap_p[sel] + 1);
            sbq.push_back(b);
        end
    endtask

    task automatic check_idle(string nm, int sel);
        chk_b({nm, "_ack"},  ack_o[sel], 1'b0);
        chk_b({nm, "_vld"},  vld_o[sel], 1'b0);
        chk_b({nm, "_last"}, lst_o[sel], 1'b0);
        chk_b({nm, "_busy"}, bsy_o[sel], 1'b0);
    endtask

    // Wait for the scoreboard to empty, optionally writing the store in cycle e+wr_off.
    task automatic drain(int sel, int e, logic wr_en, int wr_off, logic [15:0] widx, logic [63:0] wdat);
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) chk_b("ack_single_pulse", ack_o[sel], 1'b0);
            mem_we    = wr_en && (cyc == e + wr_off);
            mem_waddr = widx;
            mem_wdata = wdat;
        end
        mem_we = 1'b0;
        if (sbq.size() != 0) begin
            chk_i("beats_timeout", sbq.size(), 0);
            sbq.delete();
        end else begin
            chk_b("busy_on_last_beat", bsy_o[sel], 1'b1);
            @(negedge clk);
            check_idle("after_line", sel);
        end
    endtask

    task automatic run_req(vec_t v);
        int e;
        @(negedge clk);
        req_i[v.sel]  = 1'b1;
        addr_i[v.sel] = v.addr;
        @(negedge clk);
        e = cyc;
        chk_b("ack", ack_o[v.sel], 1'b1);
        chk_b("busy_at_ack", bsy_o[v.sel], 1'b1);
        push_line(v.sel, e, v.exp);
        req_i[v.sel] = 1'b0;
        drain(v.sel, e, v.wr_en, v.wr_off, v.wr_idx, v.wr_dat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [9];
        logic [63:0] pre [4];
        int e1, e2;

        pre = '{DB, DC, DD, DE};
        for (int i = 0; i < 3; i++) begin
            req_i[i]  = 1'b0;
            addr_i[i] = '0;
        end

        // Preload while reset is held; the store ignores reset.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_we    = 1'b1;
            mem_waddr = 16'h2020 + 16'(i);
            mem_wdata = pre[i];
        end
        @(negedge clk);
        mem_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle("reset", i);
            chk_d("reset_data", dat_o[i], 64'h0);
        end
        reset = 1'b0;

        // Back-to-back with req held high throughout.
        @(negedge clk);
        req_i[0]  = 1'b1;
        addr_i[0] = 29'h2021;
        @(negedge clk);
        e1 = cyc;
        chk_b("b2b_ack1", ack_o[0], 1'b1);
        push_line(0, e1, {DB, DE, DD, DC});
        addr_i[0] = 29'h2023;
        e2 = e1 + lat_p[0] + 3 * (gap_p[0] + 1) + 2;
        push_line(0, e2, {DD, DC, DB, DE});
        for (int c = e1 + 1; c < e2; c++) begin
            @(negedge clk);
            chk_b("b2b_no_early_ack", ack_o[0], 1'b0);
        end
        @(negedge clk);
        chk_b("b2b_ack2", ack_o[0], 1'b1);
        req_i[0] = 1'b0;
        drain(0, e2, 1'b0, 0, '0, '0);

        // Reset pulse after the second beat aborts the line.
        @(negedge clk);
        req_i[0]  = 1'b1;
        addr_i[0] = 29'h2021;
        @(negedge clk);
        e1 = cyc;
        chk_b("rst_ack", ack_o[0], 1'b1);
        push_line(0, e1, {DB, DE, DD, DC});
        req_i[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk_i("rst_beats_left", sbq.size(), 2);
        reset = 1'b1;
        sbq.delete();
        @(negedge clk);
        check_idle("mid_reset", 0);
        chk_d("mid_reset_data", dat_o[0], 64'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_b("no_beat_after_reset", vld_o[0], 1'b0);

        // Table of single requests; the last two write the store mid-line.
        vecs[0] = mk(0, 29'h2021,    DC, DD, DE, DB, 1'b0, 0, '0, '0);
        vecs[1] = mk(1, 29'h2023,    DB, DC, DD, DE, 1'b0, 0, '0, '0);
        vecs[2] = mk(2, 29'h2020,    DB, DC, DD, DE, 1'b0, 0, '0, '0);
        vecs[3] = mk(0, 29'h2023,    DE, DB, DC, DD, 1'b0, 0, '0, '0);
        vecs[4] = mk(0, 29'h1_2022,  DD, DE, DB, DC, 1'b0, 0, '0, '0);
        vecs[5] = mk(2, 29'h2022,    DD, DE, DB, DC, 1'b0, 0, '0, '0);
        vecs[6] = mk(1, 29'h2020,    DB, DC, DD, DE, 1'b0, 0, '0, '0);
        vecs[7] = mk(0, 29'h2020,    DB, DC, DD, DE, 1'b1, 4, 16'h2022, D5);
        vecs[8] = mk(0, 29'h2020,    DB, DC, D5, D7, 1'b1, 4, 16'h2023, D7);
        for (int i = 0; i < 9; i++) begin
            run_req(vecs[i]);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/biu_icu_line_responder.md
Name: biu_icu_line_responder

Overview:
Memory-side responder for the icache miss interface (icu_biu_*/biu_icu_*). It accepts one line-fill request from the icache, pulses a single-cycle ack, waits a programmable latency, then returns a 32-byte line as four 64-bit beats, critical doubleword first. Beat data is read from an internal doubleword-addressed store that the bench or boot logic preloads through a write port. The block serves as the BIU stand-in for icache unit and system tests.

Parameters:
MEM_AW, 16, doubleword-index width of the backing store (2^MEM_AW x 64 bits).
LAT, 2, cycles from the ack cycle to the first data beat; legal range 1..15.
BEAT_GAP, 0, idle cycles inserted between consecutive beats; legal range 0..3.
WRAP, 1, 1 = critical-word-first wrap order; 0 = beats returned in order from doubleword 0 of the line.

Ports:
clk  in  1  clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
icu_biu_req  in  1  line-fill request; held high by the icache until ack.
icu_biu_addr  in  29  request address [31:3]; [4:3] selects the critical doubleword.
biu_icu_ack  out  1  one-cycle acceptance pulse.
biu_icu_data_valid  out  1  beat valid.
biu_icu_data  out  64  beat data.
biu_icu_data_last  out  1  high with the 4th beat only.
biu_busy  out  1  high from request capture until the last beat.
mem_we  in  1  store write enable.
mem_waddr  in  MEM_AW  store doubleword index (equal to addr[MEM_AW+2:3]).
mem_wdata  in  64  store write data.

Behaviour:
- Reset (synchronous, active-high): state is IDLE. ack, data_valid, data_last, and busy are 0. data is 64'h0. Counters are cleared. Store contents are not reset.
- Reset asserted mid-transfer: the transfer is aborted. No further beats are sent, and outputs take reset values on the next edge.
- State machine: IDLE -> ACK -> WAIT -> BEAT -> (GAP -> BEAT)* -> IDLE.
- IDLE: if icu_biu_req=1 at edge T, capture addr and go to ACK. ack=1 and busy=1 during cycle T+1. The req level in any other state is ignored.
- ACK: lasts exactly 1 cycle. The latency counter loads LAT-1. If LAT=1, go directly to BEAT; otherwise go to WAIT.
- WAIT: decrement the counter each cycle; go to BEAT when it reaches 0. The first beat is valid in cycle T+1+LAT.
- BEAT: data_valid=1 for exactly 1 cycle, and data = store[line_base | idx].
  - line_base is addr[MEM_AW+2:5] concatenated with 2'b00.
  - With WRAP=1, idx = (addr[4:3]+k) mod 4 for beat k=0..3. With WRAP=0, idx = k.
  - The beat counter is 2 bits. data_last=1 only when k=3.
  - After a non-final beat, go to GAP if BEAT_GAP>0, otherwise stay in BEAT.
  - After the final beat, go to IDLE.
- GAP: lasts BEAT_GAP cycles with data_valid=0, then returns to BEAT.
- Outputs when not valid: data holds its last value, and last=0.
- Store addressing: bits of addr above MEM_AW+2 are ignored (aliasing).
- busy timing: busy=1 from the ACK cycle through the final-beat cycle, and 0 in IDLE.
- Back-to-back requests: a req high in the cycle after the last beat (state IDLE) is accepted at that edge. The next ack follows one cycle later, so ack never overlaps data_valid.
- Store writes:
  - Writes are allowed in any state.
  - A write to the same index as a beat being read in the same cycle returns the old data (read-before-write).
  - A write completed before that beat's cycle is visible to it.
- All outputs are registered. No combinational path exists from inputs to outputs.

Test Plan:
- Preload idx 0x2020..0x2023 = bbbb.., cccc.., dddd.., eeee.. (64-bit repeats); WRAP=1, LAT=2, BEAT_GAP=0. Request addr 0x2021 sampled at T -> ack at T+1; beats at T+3..T+6 = cccc, dddd, eeee, bbbb; last only at T+6; busy 0 at T+7.
- Same preload with WRAP=0 and addr 0x2023 -> beats bbbb, cccc, dddd, eeee; last on eeee.
- LAT=1, BEAT_GAP=2, addr 0x2020 -> first beat at T+2, beats spaced 3 cycles apart, data_valid low in the gap cycles, last at T+11.
- Back-to-back: req held high continuously -> second ack occurs 2 cycles after the first last beat, and no ack overlaps data_valid.
- Reset pulse after the 2nd beat -> next cycle has all outputs 0; a fresh request then completes normally with the preloaded data intact.
- Write idx 0x2022 = 5555.. in the same cycle as its beat -> that beat returns dddd..; a re-request returns 5555...
